cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller. It answers read hits in the same cycle and refills a 64-bit block from the SRAM controller on a read miss. Every write is forwarded to SRAM. While a request is outstanding it drops `ready`, which the top level uses as the pipeline freeze in place of the raw SRAM freeze.

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_if.sv | 26 ++
 rtl/cache_array.sv | 65 ++++++
 rtl/cache_controller.sv | 119 +++++++++++
 tb/tb_cache_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the two-way write-through data cache.
// Address fields below are taken from the effective address e = address - DATA_BASE.
package cache_pkg;
  localparam int SETS    = 64;
  localparam int TAG_W   = 10;
  localparam int BLOCK_W = 64;
  localparam int IDX_W   = 6;
  localparam int OFF_BIT = 2;
  localparam int IDX_LSB = 3;
  localparam int TAG_LSB = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WRITE = 2'd2
  } state_t;
endpackage

// File: rtl/cache_if.sv
// MEM-stage request/response and SRAM-controller handshake seen by the data cache.
// The requester holds its inputs while ready is low; the SRAM side pulses sram_ready once per request.
interface cache_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_read, sram_write, sram_address, sram_wdata
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_read, sram_write, sram_address, sram_wdata
  );
endinterface

// File: rtl/cache_array.sv
// Two-way set storage: valid/tag/block per way plus one lru bit per set.
// Lookup and victim choice are combinational; fill, word write and lru update land at the edge.
// No backpressure: the controller guarantees fill and word write are never requested together.
module cache_array
  import cache_pkg::*;
#(
  parameter int SETS  = cache_pkg::SETS,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  idx,
  input  logic [TAG_W-1:0]         tag,
  input  logic                     off,
  output logic                     hit,
  output logic                     hit_way,
  output logic [31:0]              hit_word,
  output logic                     victim,
  input  logic                     fill_en,
  input  logic [BLOCK_W-1:0]       fill_blk,
  input  logic                     wr_en,
  input  logic [31:0]              wr_word,
  input  logic                     lru_en,
  input  logic                     lru_way
);
  logic [1:0]         valid_q [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][2];
  logic [BLOCK_W-1:0] data_q  [SETS][2];
  logic [SETS-1:0]    lru_q;
  logic [1:0]         way_hit;
  logic [BLOCK_W-1:0] blk;

  always_comb begin
    for (int w = 0; w < 2; w++)
      way_hit[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    hit      = |way_hit;
    hit_way  = way_hit[1];
    blk      = data_q[idx][hit_way];
    hit_word = off ? blk[63:32] : blk[31:0];
    // Fill invalid ways first (way 0 preferred) before evicting by lru.
    if (!valid_q[idx][0])      victim = 1'b0;
    else if (!valid_q[idx][1]) victim = 1'b1;
    else                       victim = lru_q[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
      lru_q <= '0;
    end else begin
      if (fill_en) valid_q[idx][victim] <= 1'b1;
      if (lru_en)  lru_q[idx] <= ~lru_way;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= fill_blk;
    end else if (wr_en) begin
      if (off) data_q[idx][hit_way][63:32] <= wr_word;
      else     data_q[idx][hit_way][31:0]  <= wr_word;
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache between MEM stage and SRAM controller.
// Read hit: 0 added cycles; read miss and every write: 1 + SRAM latency.
// ready drops for the whole SRAM transaction and acts as the pipeline freeze.
module cache_controller
  import cache_pkg::*;
#(
  parameter int DATA_BASE = 1024,
  parameter int SETS      = cache_pkg::SETS,
  parameter int TAG_W     = cache_pkg::TAG_W
) (
  input  logic  clk,
  input  logic  rst,
  cache_if.slave bus
);
  localparam int IW = $clog2(SETS);

  state_t            state;
  logic [31:0]       e;
  logic [IW-1:0]     idx;
  logic [TAG_W-1:0]  tag;
  logic              off;
  logic              hit, hit_way, victim;
  logic [31:0]       hit_word;
  logic              fill_en, wr_en, lru_en, lru_way;

  assign e   = bus.address - 32'(DATA_BASE);
  assign idx = e[IDX_LSB +: IW];
  assign tag = e[TAG_LSB +: TAG_W];
  assign off = e[OFF_BIT];

  cache_array #(.SETS(SETS), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .tag      (tag),
    .off      (off),
    .hit      (hit),
    .hit_way  (hit_way),
    .hit_word (hit_word),
    .victim   (victim),
    .fill_en  (fill_en),
    .fill_blk (bus.sram_rdata),
    .wr_en    (wr_en),
    .wr_word  (bus.wdata),
    .lru_en   (lru_en),
    .lru_way  (lru_way)
  );

  always_comb begin
    bus.ready        = 1'b0;
    bus.rdata        = '0;
    bus.sram_read    = 1'b0;
    bus.sram_write   = 1'b0;
    bus.sram_address = '0;
    bus.sram_wdata   = '0;
    fill_en          = 1'b0;
    wr_en            = 1'b0;
    lru_en           = 1'b0;
    lru_way          = hit_way;
    unique case (state)
      IDLE: begin
        if (bus.MEM_W_EN) begin
          bus.sram_write   = 1'b1;
          bus.sram_address = e;
          bus.sram_wdata   = bus.wdata;
        end else if (bus.MEM_R_EN) begin
          if (hit) begin
            bus.ready = 1'b1;
            bus.rdata = hit_word;
            lru_en    = !rst;
          end else begin
            bus.sram_read    = 1'b1;
            bus.sram_address = {e[31:3], 3'b000};
          end
        end else begin
          bus.ready = 1'b1;
        end
      end
      RMISS: begin
        bus.sram_read    = 1'b1;
        bus.sram_address = {e[31:3], 3'b000};
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          bus.rdata = off ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
          fill_en   = !rst;
          lru_en    = !rst;
          lru_way   = victim;
        end
      end
      WRITE: begin
        bus.sram_write   = 1'b1;
        bus.sram_address = e;
        bus.sram_wdata   = bus.wdata;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          wr_en     = hit && !rst;
          lru_en    = hit && !rst;
        end
      end
      default: bus.ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.MEM_W_EN)                state <= WRITE;
          else if (bus.MEM_R_EN && !hit)   state <= RMISS;
        end
        RMISS:   if (bus.sram_ready) state <= IDLE;
        WRITE:   if (bus.sram_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: transaction-level cache and SRAM model, directed scenarios then random traffic.
module tb_cache_controller;
  localparam int DATA_BASE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_if bus();

  cache_controller #(.DATA_BASE(DATA_BASE), .SETS(64), .TAG_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference cache: per set two ways of {valid, tag, block}, lru names the victim.
  bit          mv [64][2];
  logic [9:0]  mt [64][2];
  logic [63:0] md [64][2];
  bit          ml [64];
  // Backing store, one 64-bit block per aligned effective address.
  logic [63:0] mem [logic [28:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_blk(input logic [31:0] e);
    if (!mem.exists(e[31:3])) mem[e[31:3]] = {$urandom, $urandom};
    return mem[e[31:3]];
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 1'b0;
      mv[s][1] = 1'b0;
      ml[s]    = 1'b0;
    end
  endtask

  task automatic idle(input bit pulse);
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.address    = $urandom;
    bus.sram_ready = pulse;
    @(negedge clk);
    chk("idle_ready", bus.ready, 1);
    chk("idle_sram_read", bus.sram_read, 0);
    chk("idle_sram_write", bus.sram_write, 0);
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
  endtask

  // Starts just after a rising edge, ends just after the edge that completes the request.
  task automatic do_req(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, output logic [31:0] got, output bit seen);
    logic [31:0] e;
    int          ix;
    logic [9:0]  tg;
    bit          off, hit;
    int          hw, vic;
    logic [63:0] blk;
    e   = addr - DATA_BASE;
    ix  = int'(e[8:3]);
    tg  = e[18:9];
    off = e[2];
    hit = 1'b0;
    hw  = 0;
    for (int k = 0; k < 2; k++)
      if (mv[ix][k] && mt[ix][k] == tg) begin hit = 1'b1; hw = k; end
    got  = '0;
    seen = 1'b0;
    bus.MEM_R_EN   = r;
    bus.MEM_W_EN   = w;
    bus.address    = addr;
    bus.wdata      = wd;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = {$urandom, $urandom};
    if (r && !w && hit) begin
      @(negedge clk);
      seen = bus.sram_read | bus.sram_write;
      chk("hit_ready", bus.ready, 1);
      chk("hit_rdata", bus.rdata, off ? md[ix][hw][63:32] : md[ix][hw][31:0]);
      chk("hit_sram_read", bus.sram_read, 0);
      chk("hit_sram_write", bus.sram_write, 0);
      got = bus.rdata;
      @(posedge clk); #1;
      ml[ix] = (hw == 0);
    end else begin
      blk = mem_blk(e);
      for (int c = 0; c <= lat + 1; c++) begin
        bus.sram_ready = (c == lat + 1);
        if (c == lat + 1 && !w) bus.sram_rdata = blk;
        @(negedge clk);
        if (c == 0) seen = bus.sram_read | bus.sram_write;
        chk("req_ready", bus.ready, (c == lat + 1));
        if (w) begin
          chk("wr_sram_write", bus.sram_write, 1);
          chk("wr_sram_read", bus.sram_read, 0);
          chk("wr_sram_address", bus.sram_address, e);
          chk("wr_sram_wdata", bus.sram_wdata, wd);
        end else begin
          chk("rd_sram_read", bus.sram_read, 1);
          chk("rd_sram_write", bus.sram_write, 0);
          chk("rd_sram_address", bus.sram_address, {e[31:3], 3'b000});
          if (c == lat + 1) chk("miss_rdata", bus.rdata, off ? blk[63:32] : blk[31:0]);
        end
        if (c == lat + 1) got = bus.rdata;
        @(posedge clk); #1;
      end
      bus.sram_ready = 1'b0;
      if (w) begin
        if (off) blk[63:32] = wd; else blk[31:0] = wd;
        mem[e[31:3]] = blk;
        if (hit) begin
          if (off) md[ix][hw][63:32] = wd; else md[ix][hw][31:0] = wd;
          ml[ix] = (hw == 0);
        end
      end else begin
        vic = !mv[ix][0] ? 0 : (!mv[ix][1] ? 1 : int'(ml[ix]));
        mv[ix][vic] = 1'b1;
        mt[ix][vic] = tg;
        md[ix][vic] = blk;
        ml[ix]      = (vic == 0);
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] er;
    bit          seen;
    int          kind;

    rst            = 1'b1;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.address    = '0;
    bus.wdata      = '0;
    bus.sram_rdata = '0;
    bus.sram_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ready", bus.ready, 1);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_sram_read", bus.sram_read, 0);
    chk("reset_sram_write", bus.sram_write, 0);
    @(posedge clk); #1;

    // First read misses and refills; the neighbouring word then hits.
    mem[29'd0] = 64'h00000002_00000001;
    do_req(1, 0, 32'd1024, 0, 2, got, seen);
    chk("lit_miss_1024_seen", seen, 1);
    chk("lit_miss_1024_rdata", got, 32'd1);
    do_req(1, 0, 32'd1028, 0, 0, got, seen);
    chk("lit_hit_1028_seen", seen, 0);
    chk("lit_hit_1028_rdata", got, 32'd2);

    // Eviction by lru within set 0.
    do_req(1, 0, 32'd1536, 0, 1, got, seen);
    chk("lit_miss_1536", seen, 1);
    do_req(1, 0, 32'd1024, 0, 0, got, seen);
    chk("lit_rehit_1024", seen, 0);
    do_req(1, 0, 32'd2048, 0, 0, got, seen);
    chk("lit_miss_2048", seen, 1);
    do_req(1, 0, 32'd1024, 0, 0, got, seen);
    chk("lit_still_hit_1024", seen, 0);
    do_req(1, 0, 32'd1536, 0, 3, got, seen);
    chk("lit_evicted_1536", seen, 1);

    // Write hit updates the cached word; write miss does not allocate.
    do_req(0, 1, 32'd1028, 32'hDEAD_BEEF, 2, got, seen);
    chk("lit_write_seen", seen, 1);
    do_req(1, 0, 32'd1028, 0, 0, got, seen);
    chk("lit_wr_hit_seen", seen, 0);
    chk("lit_wr_hit_rdata", got, 32'hDEAD_BEEF);
    do_req(0, 1, 32'd3000, 32'h0BAD_F00D, 1, got, seen);
    do_req(1, 0, 32'd3000, 0, 0, got, seen);
    chk("lit_no_alloc_3000", seen, 1);
    chk("lit_3000_rdata", got, 32'h0BAD_F00D);

    // Both enables: write wins.
    do_req(1, 1, 32'd1024, 32'h1234_5678, 1, got, seen);
    do_req(1, 0, 32'd1024, 0, 0, got, seen);
    chk("lit_both_en_hit", seen, 0);
    chk("lit_both_en_rdata", got, 32'h1234_5678);

    // sram_ready in IDLE is ignored.
    idle(1'b1);
    do_req(1, 0, 32'd1024, 0, 0, got, seen);
    chk("lit_idle_pulse_hit", seen, 0);

    // Reset in the middle of a miss abandons it and clears the cache.
    bus.MEM_R_EN   = 1'b1;
    bus.MEM_W_EN   = 1'b0;
    bus.address    = 32'(DATA_BASE) + 32'h4000;
    bus.sram_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_sram_read", bus.sram_read, 1);
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.MEM_R_EN   = 1'b0;
    bus.sram_ready = 1'b1;
    @(posedge clk); #1;
    rst            = 1'b0;
    @(negedge clk);
    chk("rst_post_sram_read", bus.sram_read, 0);
    chk("rst_post_ready", bus.ready, 1);
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
    model_clear();
    do_req(1, 0, 32'd1024, 0, 1, got, seen);
    chk("lit_rst_then_miss", seen, 1);

    // Random traffic over a few sets and tags, with occasional ignored high bits.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      er   = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3)
           | (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 15) == 0) er = er | 32'h0010_0000;
      if (kind < 5)      do_req(1, 0, 32'(DATA_BASE) + er, 0, $urandom_range(0, 3), got, seen);
      else if (kind < 8) do_req(0, 1, 32'(DATA_BASE) + er, $urandom, $urandom_range(0, 3), got, seen);
      else if (kind < 9) do_req(1, 1, 32'(DATA_BASE) + er, $urandom, $urandom_range(0, 3), got, seen);
      else               idle(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
